// File: rtl/uart_arb_pkg.sv
// uart_arb_pkg: shared state encoding, header nibble and width helper for the UART TX arbiter.
package uart_arb_pkg;
    typedef enum logic [1:0] {IDLE, TAG, XFER} arb_state_t;
    localparam logic [3:0] TAG_NIBBLE = 4'hF;
    function automatic int gid_w(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/uart_rr_pick.sv
// uart_rr_pick: combinational rotate-priority pick of the first set request at or after ptr_i.
module uart_rr_pick import uart_arb_pkg::*; #(
    parameter int N = 4,
    localparam int GW = gid_w(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [GW-1:0] ptr_i,
    output logic          found_o,
    output logic [GW-1:0] idx_o
);
    logic [N-1:0] rot;
    int off, sum;
    // rot[k] is request (ptr_i + k) mod N
    assign rot = N'({req_i, req_i} >> ptr_i);
    always_comb begin
        off = 0;
        for (int k = N - 1; k >= 0; k--) if (rot[k]) off = k;
        sum = int'(ptr_i) + off;
        idx_o = GW'(sum >= N ? sum - N : sum);
        found_o = |req_i;
    end
endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin, packet-locked arbiter sharing one UART TX byte stream.
// Define UART_ARB_TAG_EN to prefix each packet with a {F, grant_id} header byte.
module uart_tx_arbiter import uart_arb_pkg::*; #(
    parameter int NUM_REQ     = 4,
    parameter int DATA_W      = 8,
    parameter int MAX_PKT_LEN = 64,
    localparam int GW = gid_w(NUM_REQ),
    localparam int CW = $clog2(MAX_PKT_LEN)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    input  logic [NUM_REQ-1:0]        req_last,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic                      tx_valid,
    output logic [DATA_W-1:0]         tx_data,
    output logic                      tx_last,
    input  logic                      tx_ready,
    output logic [GW-1:0]             grant_id,
    output logic                      busy,
    output logic [NUM_REQ-1:0]        overrun_err,
    input  logic                      err_clr
);
    arb_state_t          state_q, state_d;
    logic [GW-1:0]       grant_q, grant_d, rr_q, rr_d, pick, rr_next;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [NUM_REQ-1:0]  err_q, err_d;
    logic                tx_valid_q, tx_valid_d, tx_last_q, tx_last_d;
    logic [DATA_W-1:0]   tx_data_q, tx_data_d, sel_data;
    logic                found, load, accept, at_max, sel_last;

    uart_rr_pick #(.N(NUM_REQ)) u_pick (
        .req_i   (req_valid),
        .ptr_i   (rr_q),
        .found_o (found),
        .idx_o   (pick)
    );

    assign load     = ~tx_valid_q | tx_ready;
    assign sel_data = req_data[int'(grant_q)*DATA_W +: DATA_W];
    assign sel_last = req_last[grant_q];
    assign accept   = (state_q == XFER) & req_valid[grant_q] & load;
    assign at_max   = cnt_q == CW'(MAX_PKT_LEN - 1);
    assign rr_next  = (grant_q == GW'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            grant_q    <= '0;
            rr_q       <= '0;
            cnt_q      <= '0;
            err_q      <= '0;
            tx_valid_q <= 1'b0;
            tx_data_q  <= '0;
            tx_last_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            rr_q       <= rr_d;
            cnt_q      <= cnt_d;
            err_q      <= err_d;
            tx_valid_q <= tx_valid_d;
            tx_data_q  <= tx_data_d;
            tx_last_q  <= tx_last_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        rr_d       = rr_q;
        cnt_d      = cnt_q;
        err_d      = err_clr ? '0 : err_q;
        tx_valid_d = tx_valid_q & ~load;
        tx_data_d  = tx_data_q;
        tx_last_d  = tx_last_q;
        case (state_q)
            IDLE: if (found) begin
                grant_d = pick;
                cnt_d   = '0;
`ifdef UART_ARB_TAG_EN
                state_d = TAG;
`else
                state_d = XFER;
`endif
            end
            TAG: if (load) begin
                tx_valid_d = 1'b1;
                tx_data_d  = DATA_W'({TAG_NIBBLE, 4'(grant_q)});
                tx_last_d  = 1'b0;
                state_d    = XFER;
            end
            XFER: if (accept) begin
                tx_valid_d = 1'b1;
                tx_data_d  = sel_data;
                tx_last_d  = sel_last | at_max;
                cnt_d      = cnt_q + 1'b1;
                if (sel_last | at_max) begin
                    rr_d    = rr_next;
                    state_d = IDLE;
                end
                // a new overrun wins over a simultaneous clear
                if (at_max & ~sel_last) err_d[grant_q] = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        req_ready = '0;
        if (state_q == XFER) req_ready[grant_q] = load;
        busy = state_q != IDLE;
    end

    assign tx_valid    = tx_valid_q;
    assign tx_data     = tx_data_q;
    assign tx_last     = tx_last_q;
    assign grant_id    = grant_q;
    assign overrun_err = err_q;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: self-checking bench for uart_tx_arbiter (NUM_REQ=4, MAX_PKT_LEN=4).
// Cycle vector table, directed corner sequences and random traffic against a packet-level model.
module tb_uart_tx_arbiter;
    localparam int N = 4, DW = 8, MAXL = 4;
    typedef struct packed { logic [7:0] d; logic l; } byte_t;
    typedef struct packed {
        logic [3:0] rv; logic [7:0] d0; logic [7:0] d1; logic l0; logic l1; logic tr;
        logic [3:0] rr; logic tv; logic [7:0] td; logic tl; logic [1:0] gid; logic bsy;
    } vec_t;

    logic clk = 1'b0, rst = 1'b0, tx_ready = 1'b0, err_clr = 1'b0;
    logic tx_valid, tx_last, busy;
    logic [N-1:0] req_valid = '0, req_last = '0, req_ready, overrun_err;
    logic [N*DW-1:0] req_data = '0;
    logic [DW-1:0] tx_data;
    logic [1:0] grant_id;
    int pass_cnt = 0, total = 0;
    byte_t src[N][$];
    byte_t mq[N][$];
    byte_t exp_tx[$];
    int exp_own[$];
    int src_cnt[N];
    logic [N-1:0] merr;
    vec_t tbl[16];

    always #5 clk = ~clk;

    uart_tx_arbiter #(.NUM_REQ(N), .DATA_W(DW), .MAX_PKT_LEN(MAXL)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
        .req_ready(req_ready), .tx_valid(tx_valid), .tx_data(tx_data), .tx_last(tx_last),
        .tx_ready(tx_ready), .grant_id(grant_id), .busy(busy), .overrun_err(overrun_err),
        .err_clr(err_clr)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    endtask

    function automatic logic [31:0] outs();
        return 32'({req_ready, tx_valid, tx_data, tx_last, grant_id, busy, overrun_err});
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0; req_valid = '0; req_data = '0; req_last = '0; tx_ready = 1'b0; err_clr = 1'b0;
        for (int i = 0; i < N; i++) begin src[i].delete(); src_cnt[i] = 0; end
        @(negedge clk);
        rst = 1'b1;
    endtask

    // Packet-level reference: round-robin over non-empty queues, whole packets, forced cut at MAXL.
    task automatic build_model(input int ptr);
        byte_t b;
        int g, n;
        bit done;
        exp_tx.delete(); exp_own.delete(); merr = '0;
        for (int i = 0; i < N; i++) mq[i] = src[i];
        forever begin
            g = -1;
            for (int k = N - 1; k >= 0; k--) if (mq[(ptr + k) % N].size() > 0) g = (ptr + k) % N;
            if (g < 0) break;
`ifdef UART_ARB_TAG_EN
            b.d = 8'hF0 | 8'(g); b.l = 1'b0;
            exp_tx.push_back(b);
`endif
            n = 0; done = 1'b0;
            while (!done && mq[g].size() > 0) begin
                b = mq[g].pop_front(); n++;
                if (!b.l && n == MAXL) merr[g] = 1'b1;
                b.l = b.l || n == MAXL;
                exp_tx.push_back(b); exp_own.push_back(g);
                done = b.l;
            end
            if (!done) break;
            ptr = (g + 1) % N;
        end
    endtask

    task automatic run_stream(input string tag, input int ptr, input bit rnd, input int budget);
        byte_t b;
        int own;
        bit stall;
        build_model(ptr);
        for (int cyc = 0; cyc < budget && exp_tx.size() > 0; cyc++) begin
            @(negedge clk);
            tx_ready = rnd ? ($urandom_range(3) != 0) : 1'b1;
            for (int i = 0; i < N; i++) begin
                stall = rnd && src_cnt[i] != 0 && $urandom_range(3) == 0;
                req_valid[i] = src[i].size() > 0 && !stall;
                b = src[i].size() > 0 ? src[i][0] : '0;
                req_data[i*DW +: DW] = b.d;
                req_last[i] = b.l;
            end
            #1;
            if (tx_valid && tx_ready) begin
                b = exp_tx.pop_front();
                chk({tag, " tx"}, 32'({tx_data, tx_last}), 32'(b));
            end
            for (int i = 0; i < N; i++) if (req_valid[i] && req_ready[i]) begin
                own = exp_own.size() > 0 ? exp_own.pop_front() : -1;
                chk({tag, " owner"}, 32'(i), 32'(own));
                b = src[i].pop_front();
                src_cnt[i] = (b.l || src_cnt[i] == MAXL - 1) ? 0 : src_cnt[i] + 1;
            end
        end
        chk({tag, " drain"}, 32'(exp_tx.size()), 32'd0);
        @(negedge clk);
        req_valid = '0; tx_ready = 1'b1;
    endtask

    task automatic push(input int i, input logic [7:0] d, input logic l);
        byte_t b;
        b.d = d; b.l = l;
        src[i].push_back(b);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int npk, len;
        repeat (2) @(negedge clk);
        chk("reset", outs(), 32'd0);
`ifndef UART_ARB_TAG_EN
        tbl[0]  = {4'b0001, 8'h41, 8'h00, 3'b001, 4'b0000, 1'b0, 8'h00, 1'b0, 2'd0, 1'b0};
        tbl[1]  = {4'b0001, 8'h41, 8'h00, 3'b001, 4'b0001, 1'b0, 8'h00, 1'b0, 2'd0, 1'b1};
        tbl[2]  = {4'b0001, 8'h42, 8'h00, 3'b001, 4'b0001, 1'b1, 8'h41, 1'b0, 2'd0, 1'b1};
        tbl[3]  = {4'b0001, 8'h43, 8'h00, 3'b101, 4'b0001, 1'b1, 8'h42, 1'b0, 2'd0, 1'b1};
        tbl[4]  = {4'b0011, 8'h44, 8'h51, 3'b011, 4'b0000, 1'b1, 8'h43, 1'b1, 2'd0, 1'b0};
        tbl[5]  = {4'b0011, 8'h44, 8'h51, 3'b011, 4'b0010, 1'b0, 8'h43, 1'b1, 2'd1, 1'b1};
        tbl[6]  = {4'b0001, 8'h44, 8'h00, 3'b001, 4'b0000, 1'b1, 8'h51, 1'b1, 2'd1, 1'b0};
        tbl[7]  = {4'b0001, 8'h44, 8'h00, 3'b001, 4'b0001, 1'b0, 8'h51, 1'b1, 2'd0, 1'b1};
        for (int r = 8; r < 13; r++)
            tbl[r] = {4'b0001, 8'h45, 8'h00, 3'b100, 4'b0000, 1'b1, 8'h44, 1'b0, 2'd0, 1'b1};
        tbl[13] = {4'b0001, 8'h45, 8'h00, 3'b101, 4'b0001, 1'b1, 8'h44, 1'b0, 2'd0, 1'b1};
        tbl[14] = {4'b0000, 8'h00, 8'h00, 3'b001, 4'b0000, 1'b1, 8'h45, 1'b1, 2'd0, 1'b0};
        tbl[15] = {4'b0000, 8'h00, 8'h00, 3'b001, 4'b0000, 1'b0, 8'h45, 1'b1, 2'd0, 1'b0};
        do_reset();
        for (int r = 0; r < 16; r++) begin
            @(negedge clk);
            req_valid = tbl[r].rv;
            req_data  = {16'h0, tbl[r].d1, tbl[r].d0};
            req_last  = {2'b00, tbl[r].l1, tbl[r].l0};
            tx_ready  = tbl[r].tr;
            #1;
            chk($sformatf("vec%0d", r),
                32'({req_ready, tx_valid, tx_data, tx_last, grant_id, busy}),
                32'({tbl[r].rr, tbl[r].tv, tbl[r].td, tbl[r].tl, tbl[r].gid, tbl[r].bsy}));
        end
`else
        do_reset();
        push(1, 8'h55, 1'b1);
        run_stream("tag", 0, 1'b0, 50);
`endif
        // all four requesters with 2-byte packets from reset
        do_reset();
        for (int i = 0; i < N; i++) begin
            push(i, 8'(16 * (i + 1) + 1), 1'b0);
            push(i, 8'(16 * (i + 1) + 2), 1'b1);
        end
        run_stream("rr4", 0, 1'b0, 100);

        // req2 overruns MAX_PKT_LEN and never signals last
        do_reset();
        for (int k = 0; k < 6; k++) push(2, 8'hA0 + 8'(k), 1'b0);
        run_stream("ovr", 0, 1'b0, 100);
        chk("ovr err", 32'(overrun_err), 32'h4);
        chk("ovr lock", 32'({busy, grant_id}), 32'({1'b1, 2'd2}));
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        chk("err_clr", 32'(overrun_err), 32'd0);

        // asynchronous reset mid-packet, pointer must restart at 0
        do_reset();
        push(1, 8'h61, 1'b1);
        run_stream("pre", 0, 1'b0, 50);
        @(negedge clk);
        req_valid = 4'b1000; req_data[31:24] = 8'h71; req_last = '0; tx_ready = 1'b1;
        repeat (2) @(negedge clk);
        #1 chk("mid pkt", 32'({busy, grant_id}), 32'({1'b1, 2'd3}));
        rst = 1'b0;
        #1 chk("async rst", outs(), 32'd0);
        do_reset();
        push(1, 8'h62, 1'b1);
        push(3, 8'h72, 1'b1);
        run_stream("post", 0, 1'b0, 50);

        // randomized traffic with backpressure and mid-packet valid drops
        for (int it = 0; it < 4; it++) begin
            do_reset();
            for (int i = 0; i < N; i++) begin
                npk = $urandom_range(3);
                for (int p = 0; p < npk; p++) begin
                    len = $urandom_range(1, 6);
                    for (int k = 0; k < len; k++) push(i, 8'($urandom), k == len - 1);
                end
            end
            run_stream($sformatf("rnd%0d", it), 0, 1'b1, 3000);
            chk("rnd err", 32'(overrun_err), 32'(merr));
        end

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares the single UART transmit path among NUM_REQ byte-stream requesters, such as the counter-value reporter, the command echo and the status/error reporter.
- Grants are round-robin and locked per packet: a packet always goes out contiguously.
- Output is a valid/ready byte stream that feeds the TX FIFO write side, with tx_ready driven by the FIFO's not-full.
- A watchdog forces release if a requester never signals last.

Parameters:
- NUM_REQ, 4, number of requesters (legal range 2..8).
- DATA_W, 8, byte width (must be at least 8).
- MAX_PKT_LEN, 64, maximum data bytes per grant before a forced release (at least 2).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- req_valid  in  NUM_REQ  per-requester byte valid.
- req_data  in  NUM_REQ*DATA_W  flattened bytes; requester i occupies bits [i*DATA_W +: DATA_W].
- req_last  in  NUM_REQ  marks the final byte of the packet.
- req_ready  out  NUM_REQ  byte accepted on valid&ready.
- tx_valid  out  1  output byte valid.
- tx_data  out  DATA_W  output byte.
- tx_last  out  1  final byte of the current packet.
- tx_ready  in  1  downstream can accept (~tx_fifo_full).
- grant_id  out  $clog2(NUM_REQ)  current or last granted requester.
- busy  out  1  a grant is held (state is not IDLE).
- overrun_err  out  NUM_REQ  sticky flag: requester exceeded MAX_PKT_LEN.
- err_clr  in  1  synchronous clear of overrun_err.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE; tx_valid=0; tx_data=0; tx_last=0.
  - grant_id=0; rr_ptr=0; byte_cnt=0; overrun_err=0; req_ready=0.
- Output register:
  - Load when (~tx_valid | tx_ready).
  - tx_valid drops only when tx_ready=1 and nothing new is loaded.
  - tx_data and tx_last are held stable while tx_valid=1 and tx_ready=0.
- State IDLE:
  - If any req_valid is set, pick the first requester at or after rr_ptr (cyclic search), register grant_id, clear byte_cnt, go to XFER.
  - req_ready is all 0 in IDLE.
- State XFER:
  - req_ready[grant_id] = (~tx_valid | tx_ready); all other bits are 0.
  - On accept: the byte goes to the output register and byte_cnt increments.
- Release:
  - Normal release: on an accepted byte with req_last=1. tx_last=1 on that byte, rr_ptr=grant_id+1 (mod NUM_REQ), go to IDLE.
  - Forced release: on an accepted byte with byte_cnt==MAX_PKT_LEN-1 and req_last=0. The arbiter forces tx_last=1, sets overrun_err[grant_id], and releases exactly as above.
- Latency: req_valid asserted while IDLE gives grant the next cycle and byte accepted that same cycle; tx_valid rises one cycle after acceptance (2 cycles total).
- Minimum packet gap is one IDLE cycle. The next arbitration may overlap the output register still holding the previous last byte.
- Granted requester drops req_valid mid-packet: the grant stays locked and the arbiter waits indefinitely (the watchdog counts bytes, not cycles).
- Non-granted requesters are never given ready; their valid and data must stay held.
- Only one requester has valid: it is re-granted on consecutive packets.
- err_clr and a new overrun in the same cycle: set wins.
- grant_id holds its value in IDLE until the next grant.

Optional Feature:
- Macro: UART_ARB_TAG_EN.
- When defined:
  - After a grant, a TAG state emits one header byte, {4'hF, grant_id zero-extended to 4 bits} (requires NUM_REQ at most 8), through the output register before the data bytes.
  - The header has tx_last=0 and does not count toward MAX_PKT_LEN.
  - req_ready stays 0 during TAG.
  - First data tx_valid is therefore one cycle later than without the tag.
- When undefined: no TAG state; packets pass through unmodified.

Decomposition:
- Package uart_arb_pkg holds:
  - state enum arb_state_t {IDLE, TAG, XFER};
  - TAG_NIBBLE=4'hF;
  - helper function for the grant-id width.
- One sub-module, uart_rr_pick: combinational rotate-priority pick (req vector, rr_ptr) -> (found, index). It is instantiated once.

Test Plan:
- Only req0 sends the 3-byte packet 41,42,43 (last on 43), tx_ready=1:
  - tx emits 41,42,43 on consecutive cycles, first tx_valid 2 cycles after req_valid;
  - tx_last only on 43; grant_id=0; rr_ptr=1 afterwards.
- req0..req3 all valid with 2-byte packets simultaneously from reset: packets leave in order 0,1,2,3 without interleaving; req1..3 see ready=0 until granted.
- tx_ready held 0 for 5 cycles mid-packet: tx_data stays stable, req_ready=0, and no byte is lost or duplicated after release.
- MAX_PKT_LEN=4, req2 streams 6 bytes without last:
  - 4th byte has tx_last=1 and overrun_err=4'b0100;
  - req2 is re-arbitrated later for the remaining bytes;
  - err_clr then returns overrun_err to 0.
- rst pulled low mid-packet: all outputs return to their reset values immediately, and the next packet starts cleanly with the arbitration pointer at 0.
- With UART_ARB_TAG_EN, req1 sends 55 (last): tx emits F1 then 55 (tx_last on 55 only).
